// File: rtl/data_mem_arb_pkg.sv
// Shared helpers for the N-port data-memory arbiter.
// DATA_MEM_ARB_RR_EN selects round-robin instead of fixed priority.
package data_mem_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Width of a port/slot index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int m);
    return $clog2(m + 1);
  endfunction

`ifdef DATA_MEM_ARB_RR_EN
  localparam arb_mode_e ARB_MODE = ARB_RR;
`else
  localparam arb_mode_e ARB_MODE = ARB_FIXED;
`endif

endpackage

// File: rtl/data_mem_arb_tag_fifo.sv
// In-order FIFO of requester indices for granted-but-unanswered requests.
// Head is read combinationally so the response can be routed in the same cycle.
module data_mem_arb_tag_fifo
  import data_mem_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 1,
  localparam int PTR_W = idx_width(DEPTH),
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [W-1:0]     data_i,
  input  logic             pop_i,
  output logic [W-1:0]     data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/data_mem_arbiter_n.sv
// N-port arbiter onto one OBI-style data port with in-order response routing.
// Define DATA_MEM_ARB_RR_EN for round-robin; otherwise lowest index wins.
module data_mem_arbiter_n
  import data_mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4,
  localparam int BE_W  = DATA_W / 8,
  localparam int IDX_W = idx_width(NUM_PORTS),
  localparam int CNT_W = cnt_width(MAX_OUTST)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_PORTS-1:0]              req_i,
  input  logic [NUM_PORTS-1:0]              we_i,
  input  logic [NUM_PORTS-1:0][BE_W-1:0]    be_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  addr_i,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  wdata_i,
  output logic [NUM_PORTS-1:0]              gnt_o,
  output logic [NUM_PORTS-1:0]              rvalid_o,
  output logic [NUM_PORTS-1:0]              err_o,
  output logic [DATA_W-1:0]                 rdata_o,
  output logic                              data_req_o,
  output logic                              data_we_o,
  output logic [BE_W-1:0]                   data_be_o,
  output logic [ADDR_W-1:0]                 data_addr_o,
  output logic [DATA_W-1:0]                 data_wdata_o,
  input  logic                              data_gnt_i,
  input  logic                              data_rvalid_i,
  input  logic                              data_err_i,
  input  logic [DATA_W-1:0]                 data_rdata_i,
  output logic [CNT_W-1:0]                  outst_cnt_o,
  output logic                              proto_err_o
);

  logic             any_req, lock_drop, hs, pop;
  logic             fifo_full, fifo_empty;
  logic             lock_q;
  logic [IDX_W-1:0] lock_idx_q;
  logic [IDX_W-1:0] arb_idx, sel, mux_idx, head_idx;
  logic             proto_err_q;

  assign any_req   = |req_i;
  assign lock_drop = lock_q && !req_i[lock_idx_q];

`ifdef DATA_MEM_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr_q;

  always_comb begin
    int   j;
    logic found;
    arb_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!found && req_i[j]) begin
        found   = 1'b1;
        arb_idx = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (hs) begin
      rr_ptr_q <= (sel == IDX_W'(NUM_PORTS - 1)) ? '0 : sel + IDX_W'(1);
    end
  end
`else
  always_comb begin
    arb_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_i[i]) arb_idx = IDX_W'(i);
    end
  end
`endif

  // A dropped lock suppresses the request for one cycle; re-arbitration follows.
  assign sel        = (lock_q && !lock_drop) ? lock_idx_q : arb_idx;
  assign mux_idx    = any_req ? sel : '0;
  assign data_req_o = any_req && !fifo_full && !lock_drop;
  assign hs         = data_req_o && data_gnt_i;
  assign pop        = data_rvalid_i && !fifo_empty;

  assign data_we_o    = we_i[mux_idx];
  assign data_be_o    = be_i[mux_idx];
  assign data_addr_o  = addr_i[mux_idx];
  assign data_wdata_o = wdata_i[mux_idx];
  assign rdata_o      = data_rdata_i;
  assign proto_err_o  = proto_err_q;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign gnt_o[gi]    = hs && (sel == IDX_W'(gi));
    assign rvalid_o[gi] = pop && (head_idx == IDX_W'(gi));
    assign err_o[gi]    = rvalid_o[gi] && data_err_i;
  end

  data_mem_arb_tag_fifo #(
    .DEPTH (MAX_OUTST),
    .W     (IDX_W)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (hs),
    .data_i  (sel),
    .pop_i   (pop),
    .data_o  (head_idx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outst_cnt_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (lock_drop || hs) begin
      lock_q     <= 1'b0;
    end else if (data_req_o && !data_gnt_i) begin
      lock_q     <= 1'b1;
      lock_idx_q <= sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      proto_err_q <= 1'b0;
    end else if (lock_drop || (data_rvalid_i && fifo_empty)) begin
      proto_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter_n.sv
// Directed bench for data_mem_arbiter_n (3 ports, depth 4); the
// DATA_MEM_ARB_RR_EN build swaps the fixed-priority section for round-robin.
module tb_data_mem_arbiter_n;

  localparam int NP = 3;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [NP-1:0]     req, we;
  logic [NP-1:0][3:0]  be;
  logic [NP-1:0][31:0] addr, wdata;
  logic [NP-1:0]     gnt, rvalid, err;
  logic [31:0]       rdata;
  logic              data_req, data_we;
  logic [3:0]        data_be;
  logic [31:0]       data_addr, data_wdata;
  logic              data_gnt, data_rvalid, data_err;
  logic [31:0]       data_rdata;
  logic [2:0]        outst;
  logic              proto_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_arbiter_n #(
    .NUM_PORTS (NP),
    .ADDR_W    (32),
    .DATA_W    (32),
    .MAX_OUTST (4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_i         (req),
    .we_i          (we),
    .be_i          (be),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .gnt_o         (gnt),
    .rvalid_o      (rvalid),
    .err_o         (err),
    .rdata_o       (rdata),
    .data_req_o    (data_req),
    .data_we_o     (data_we),
    .data_be_o     (data_be),
    .data_addr_o   (data_addr),
    .data_wdata_o  (data_wdata),
    .data_gnt_i    (data_gnt),
    .data_rvalid_i (data_rvalid),
    .data_err_i    (data_err),
    .data_rdata_i  (data_rdata),
    .outst_cnt_o   (outst),
    .proto_err_o   (proto_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h @%0t", tag, got, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = '0; we = '0; data_gnt = 1'b0; data_rvalid = 1'b0; data_err = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0;
    idle();
    data_rdata = 32'h0;
    addr[0] = 32'h100;  addr[1] = 32'h200;  addr[2] = 32'h300;
    wdata[0] = 32'hA0A0_0000; wdata[1] = 32'hB0B0_1111; wdata[2] = 32'hC0C0_2222;
    be[0] = 4'h1; be[1] = 4'h3; be[2] = 4'hF;
    #2;
    check("rst_gnt", gnt, 3'b000);
    check("rst_rvalid", rvalid, 3'b000);
    check("rst_outst", outst, 0);
    check("rst_proto", proto_err, 0);
    tick(); tick();
    rst_ni = 1'b1;

`ifndef DATA_MEM_ARB_RR_EN
    // fixed priority: port 0 wins while it requests
    req = 3'b011; data_gnt = 1'b1; #1;
    check("fix_gnt0", gnt, 3'b001);
    check("fix_addr0", data_addr, 32'h100);
    check("fix_req", data_req, 1);
    tick();
    check("fix_gnt0b", gnt, 3'b001);
    check("fix_outst1", outst, 1);
    tick();
    req = 3'b010; #1;
    check("fix_gnt1", gnt, 3'b010);
    check("fix_addr1", data_addr, 32'h200);
    tick();
    req = 3'b111; #1;
    check("fix_gnt_all", gnt, 3'b001);
    req = '0; data_gnt = 1'b0; #1;
    check("fix_outst3", outst, 3);
    check("noreq_dreq", data_req, 0);
    check("noreq_addr", data_addr, 32'h100);
    data_rvalid = 1'b1; data_rdata = 32'h1111_2222; #1;
    check("fix_rv_a", rvalid, 3'b001);
    check("fix_rdata", rdata, 32'h1111_2222);
    tick();
    check("fix_rv_b", rvalid, 3'b001);
    tick();
    check("fix_rv_c", rvalid, 3'b010);
    tick();
    data_rvalid = 1'b0; #1;
    check("fix_drain", outst, 0);
`endif

    // interleaved load / store / load, in-order responses
    req = 3'b001; we = 3'b000; data_gnt = 1'b1; #1;
    check("il_gnt_a", gnt, 3'b001);
    check("il_we_a", data_we, 0);
    tick();
    req = 3'b010; we = 3'b010; #1;
    check("il_gnt_b", gnt, 3'b010);
    check("il_we_b", data_we, 1);
    check("il_wdata_b", data_wdata, 32'hB0B0_1111);
    check("il_be_b", data_be, 4'h3);
    tick();
    req = 3'b001; we = 3'b000; #1;
    check("il_gnt_c", gnt, 3'b001);
    tick();
    idle();
    data_rvalid = 1'b1; #1;
    check("il_rv1", rvalid, 3'b001);
    check("il_err1", err, 3'b000);
    tick();
    data_err = 1'b1; #1;
    check("il_rv2", rvalid, 3'b010);
    check("il_err2", err, 3'b010);
    tick();
    data_err = 1'b0; #1;
    check("il_rv3", rvalid, 3'b001);
    check("il_err3", err, 3'b000);
    tick();
    data_rvalid = 1'b0;

    // outstanding window full
    req = 3'b001; data_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("full_fill_gnt", gnt, 3'b001);
      tick();
    end
    check("full_cnt", outst, 4);
    check("full_dreq", data_req, 0);
    check("full_gnt", gnt, 3'b000);
    data_rvalid = 1'b1; #1;
    check("full_nobypass", data_req, 0);
    check("full_rv", rvalid, 3'b001);
    tick();
    data_rvalid = 1'b0; #1;
    check("full_cnt3", outst, 3);
    check("full_dreq_again", data_req, 1);
    check("full_gnt_again", gnt, 3'b001);
    tick();
    idle();
    data_rvalid = 1'b1;
    tick(); tick(); tick(); tick();
    data_rvalid = 1'b0; #1;
    check("full_drain", outst, 0);

    // lock holds port 1 while port 0 joins
    req = 3'b010; data_gnt = 1'b0; #1;
    check("lock_addr0", data_addr, 32'h200);
    check("lock_gnt0", gnt, 3'b000);
    tick();
    req = 3'b011; #1;
    check("lock_addr1", data_addr, 32'h200);
    tick();
    check("lock_addr2", data_addr, 32'h200);
    check("lock_gnt2", gnt, 3'b000);
    data_gnt = 1'b1; #1;
    check("lock_gnt", gnt, 3'b010);
    check("lock_addr3", data_addr, 32'h200);
    tick();
    check("unlock_gnt", gnt, 3'b001);
    tick();
    idle();
    data_rvalid = 1'b1; #1;
    check("lock_rv1", rvalid, 3'b010);
    tick();
    check("lock_rv2", rvalid, 3'b001);
    tick();
    data_rvalid = 1'b0;

    // locked requester drops its request
    req = 3'b001; data_gnt = 1'b0; #1;
    tick();
    check("drop_proto0", proto_err, 0);
    req = 3'b010; data_gnt = 1'b1; #1;
    check("drop_dreq", data_req, 0);
    check("drop_gnt", gnt, 3'b000);
    tick();
    check("drop_proto1", proto_err, 1);
    check("drop_regnt", gnt, 3'b010);
    tick();
    idle();
    rst_ni = 1'b0; #1;
    check("async_proto", proto_err, 0);
    check("async_outst", outst, 0);
    tick();
    rst_ni = 1'b1;

    // response with empty FIFO
    #1;
    check("empty_outst", outst, 0);
    data_rvalid = 1'b1; data_rdata = 32'h55; #1;
    check("empty_rv", rvalid, 3'b000);
    tick();
    data_rvalid = 1'b0; #1;
    check("empty_proto", proto_err, 1);
    tick(); tick();
    check("empty_sticky", proto_err, 1);
    rst_ni = 1'b0; #1;
    check("empty_proto_rst", proto_err, 0);
    tick();
    rst_ni = 1'b1;

    // reset mid-operation discards tags
    req = 3'b001; data_gnt = 1'b1;
    tick(); tick();
    idle(); #1;
    check("mid_outst2", outst, 2);
    rst_ni = 1'b0; #1;
    check("mid_outst0", outst, 0);
    tick();
    rst_ni = 1'b1;
    data_rvalid = 1'b1; #1;
    check("mid_rv", rvalid, 3'b000);
    tick();
    data_rvalid = 1'b0; #1;
    check("mid_proto", proto_err, 1);

`ifdef DATA_MEM_ARB_RR_EN
    rst_ni = 1'b0; #1;
    tick();
    rst_ni = 1'b1;
    req = 3'b111; data_gnt = 1'b1;
    for (int k = 0; k < 7; k++) begin
      logic [2:0] exp_gnt;
      exp_gnt = 3'b001 << (k % 3);
      #1;
      check("rr_order", gnt, exp_gnt);
      tick();
      data_rvalid = 1'b1;
    end
    rst_ni = 1'b0; #1;
    check("rr_rst_outst", outst, 0);
    tick();
    rst_ni = 1'b1;
    data_rvalid = 1'b0; #1;
    check("rr_ptr_rst", gnt, 3'b001);
    idle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
